// File: rtl/mac_acc_q8_if.sv
// Beat/result bundle for the int8 MAC accumulator front end.
// Handshake: a transfer happens on a rising clk edge where valid && ready; the
// source holds its payload stable while valid is high and ready is low.
interface mac_acc_q8_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_act;
  logic [DATA_W-1:0] in_wgt;
  logic              in_last;
  logic [DATA_W-1:0] zp_in;
  logic [ACC_W-1:0]  bias;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_len;
  logic              out_ovf;

  modport master (
    output in_valid, in_act, in_wgt, in_last, zp_in, bias, out_ready,
    input  in_ready, out_valid, out_acc, out_len, out_ovf
  );

  modport slave (
    input  in_valid, in_act, in_wgt, in_last, zp_in, bias, out_ready,
    output in_ready, out_valid, out_acc, out_len, out_ovf
  );
endinterface

// File: rtl/mac_acc_q8.sv
// Int8 multiply-accumulate front end producing signed int32 accumulator words.
// Define MAC_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mac_acc_q8 #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mac_acc_q8_if.slave   bus,
  output logic          dbg_state
);

  localparam int PW = 2 * DATA_W + 1;

  typedef enum logic {
    S_FIRST = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;

  logic              out_valid_q;
  logic [ACC_W-1:0]  out_acc_q;
  logic [CNT_W-1:0]  out_len_q;
  logic              out_ovf_q;

  logic              first;
  logic              in_ready_c;
  logic              accept;
  logic [DATA_W:0]   diff;
  logic signed [PW-1:0] diff_x;
  logic signed [PW-1:0] wgt_x;
  logic signed [PW-1:0] prod;
  logic [ACC_W:0]    prod_x;
  logic [ACC_W:0]    base_x;
  logic [ACC_W:0]    sum;
  logic              ovf_step;
  logic [ACC_W-1:0]  acc_next;
  logic [CNT_W-1:0]  cnt_next;
  logic              ovf_next;

  assign first      = (state == S_FIRST);
  // Ready depends only on the output register and out_ready, never on in_valid.
  assign in_ready_c = !out_valid_q || bus.out_ready;
  assign accept     = bus.in_valid && in_ready_c;

  assign diff   = {bus.in_act[DATA_W-1], bus.in_act} - {bus.zp_in[DATA_W-1], bus.zp_in};
  assign diff_x = {{(PW-DATA_W-1){diff[DATA_W]}}, diff};
  assign wgt_x  = {{(PW-DATA_W){bus.in_wgt[DATA_W-1]}}, bus.in_wgt};
  assign prod   = diff_x * wgt_x;
  assign prod_x = {{(ACC_W+1-PW){prod[PW-1]}}, prod};

  assign base_x   = first ? {bus.bias[ACC_W-1], bus.bias} : {acc[ACC_W-1], acc};
  assign sum      = base_x + prod_x;
  // One guard bit is enough: both addends fit in ACC_W bits.
  assign ovf_step = sum[ACC_W] ^ sum[ACC_W-1];
  assign ovf_next = (first ? 1'b0 : ovf) | ovf_step;
  assign cnt_next = first ? CNT_W'(1) : cnt + CNT_W'(1);

`ifdef MAC_ACC_SAT_EN
  assign acc_next = ovf_step ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FIRST;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_len_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        if (bus.in_last) begin
          // A result loaded here overrides the clear above: back-to-back results.
          out_acc_q   <= acc_next;
          out_len_q   <= cnt_next;
          out_ovf_q   <= ovf_next;
          out_valid_q <= 1'b1;
          state       <= S_FIRST;
          acc         <= '0;
          cnt         <= '0;
          ovf         <= 1'b0;
        end else begin
          state <= S_ACCUM;
          acc   <= acc_next;
          cnt   <= cnt_next;
          ovf   <= ovf_next;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_ovf   = out_ovf_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mac_acc_q8.sv
// Self-checking bench for mac_acc_q8: directed cases plus random vectors
// against a longint reference model of the accumulation rules.
module tb_mac_acc_q8;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 16;
  localparam int EW     = ACC_W + CNT_W + 1;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n;
  logic dbg_state;

  mac_acc_q8_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  mac_acc_q8 #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic signed [DATA_W-1:0] vec_act[$];
  logic signed [DATA_W-1:0] vec_wgt[$];
  bit rand_rdy = 1'b0;
  int valid_run = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: plain integer arithmetic over the whole vector
  function automatic logic [EW-1:0] model_vec(input logic signed [DATA_W-1:0] zp,
                                              input logic signed [ACC_W-1:0] b);
    longint a;
    longint p;
    longint s;
    logic [63:0] s_bits;
    logic [31:0] t;
    bit ov;
    logic [CNT_W-1:0] n;
    a  = longint'(b);
    ov = 1'b0;
    n  = '0;
    foreach (vec_act[i]) begin
      p = (longint'(vec_act[i]) - longint'(zp)) * longint'(vec_wgt[i]);
      s = a + p;
      n = n + 1'b1;
      if (s > MAXV || s < MINV) begin
        ov = 1'b1;
`ifdef MAC_ACC_SAT_EN
        a = (s > MAXV) ? MAXV : MINV;
`else
        s_bits = s;
        t = s_bits[31:0];
        a = longint'($signed(t));
`endif
      end else begin
        a = s;
      end
    end
    s_bits = a;
    return {s_bits[31:0], n, ov};
  endfunction

  // scoreboard: every consumed result is matched against the expected queue
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_run = 0;
    end else begin
      valid_run = bus.out_valid ? valid_run + 1 : 0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
        else chk("result", {bus.out_acc, bus.out_len, bus.out_ovf}, exp_q.pop_front());
      end
    end
  end

  // driver tasks; all start and end at posedge+1
  task automatic drive_beat(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] w,
                            input logic [DATA_W-1:0] z, input logic [ACC_W-1:0] b,
                            input logic last, input bit gap);
    int waitc;
    if (gap) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    bus.in_valid = 1'b1;
    bus.in_act   = a;
    bus.in_wgt   = w;
    bus.zp_in    = z;
    bus.bias     = b;
    bus.in_last  = last;
    waitc = 0;
    @(negedge clk);
    while (!bus.in_ready && waitc < 50) begin
      waitc++;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    chk("beat_accept", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [DATA_W-1:0] z, input logic [ACC_W-1:0] b, input bit gaps);
    logic [EW-1:0] e;
    e = model_vec(z, b);
    for (int i = 0; i < vec_act.size(); i++)
      drive_beat(vec_act[i], vec_wgt[i], z, b, (i == vec_act.size() - 1), gaps && (i > 0));
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string tag, input logic [ACC_W-1:0] a,
                           input logic [CNT_W-1:0] n, input logic o);
    @(negedge clk);
    chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({tag, "_acc"}, {32'd0, bus.out_acc}, {32'd0, a});
    chk({tag, "_len"}, {48'd0, bus.out_len}, {48'd0, n});
    chk({tag, "_ovf"}, {63'd0, bus.out_ovf}, {63'd0, o});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", {63'd0, (exp_q.size() == 0)}, 64'd1);
  endtask

  initial begin
    logic [EW-1:0] held;
    logic [EW-1:0] e;
    int len;
    bus.in_valid  = 1'b0;
    bus.in_act    = '0;
    bus.in_wgt    = '0;
    bus.in_last   = 1'b0;
    bus.zp_in     = '0;
    bus.bias      = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_acc", {32'd0, bus.out_acc}, 64'd0);
    chk("rst_out_len", {48'd0, bus.out_len}, 64'd0);
    chk("rst_out_ovf", {63'd0, bus.out_ovf}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_state", {63'd0, dbg_state}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // three-beat vector with zero-point
    vec_act = '{8'sd10, -8'sd5, 8'sd127};
    vec_wgt = '{8'sd2, 8'sd3, -8'sd1};
    send_vec(-8'sd3, 32'sd100, 1'b0);
    check_out("t1", -32'sd10, 16'd3, 1'b0);

    // single beat, most negative operands
    vec_act = '{-8'sd128};
    vec_wgt = '{-8'sd128};
    send_vec(8'sd0, 32'sd0, 1'b0);
    check_out("t2", 32'd16384, 16'd1, 1'b0);

    // overflow on the first beat
    vec_act = '{8'sd127};
    vec_wgt = '{8'sd127};
    send_vec(8'sd0, 32'sd2147483600, 1'b0);
`ifdef MAC_ACC_SAT_EN
    check_out("t3", 32'h7FFF_FFFF, 16'd1, 1'b1);
`else
    check_out("t3", 32'h8000_3ED1, 16'd1, 1'b1);
`endif

    // backpressure holds the result and stalls the input
    drain();
    bus.out_ready = 1'b0;
    vec_act = '{8'sd3};
    vec_wgt = '{8'sd4};
    send_vec(8'sd1, 32'sd5, 1'b0);
    held = exp_q[0];
    bus.in_valid = 1'b1;
    bus.in_act   = 8'sd2;
    bus.in_wgt   = 8'sd2;
    bus.zp_in    = 8'sd0;
    bus.bias     = 32'sd0;
    bus.in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("stall_hold", {15'd0, bus.out_valid, bus.out_acc, bus.out_len, bus.out_ovf},
          {15'd0, 1'b1, held});
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    vec_act = '{8'sd2};
    vec_wgt = '{8'sd2};
    e = model_vec(8'sd0, 32'sd0);
    @(negedge clk);
    chk("resume_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    exp_q.push_back(e);
    check_out("t4", 32'd4, 16'd1, 1'b0);

    // back-to-back single-beat vectors, no bubble
    drain();
    vec_act = '{8'sd1};
    vec_wgt = '{8'sd1};
    send_vec(8'sd0, 32'sd10, 1'b0);
    vec_act = '{8'sd2};
    vec_wgt = '{8'sd2};
    send_vec(8'sd0, 32'sd20, 1'b0);
    @(negedge clk); #1;
    chk("b2b_valid_run", 64'(valid_run), 64'd2);
    @(posedge clk); #1;

    // reset in the middle of a vector
    drain();
    drive_beat(8'sd50, 8'sd50, 8'sd0, 32'sd1000, 1'b0, 1'b0);
    drive_beat(8'sd60, 8'sd60, 8'sd0, 32'sd1000, 1'b0, 1'b0);
    chk("mid_state", {63'd0, dbg_state}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_acc", {32'd0, bus.out_acc}, 64'd0);
    chk("mid_rst_len", {48'd0, bus.out_len}, 64'd0);
    chk("mid_rst_state", {63'd0, dbg_state}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    vec_act = '{8'sd1};
    vec_wgt = '{8'sd1};
    send_vec(8'sd0, 32'sd7, 1'b0);
    check_out("t6", 32'd8, 16'd1, 1'b0);

    // random vectors with idle gaps and random backpressure
    drain();
    rand_rdy = 1'b1;
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 6);
      vec_act.delete();
      vec_wgt.delete();
      for (int i = 0; i < len; i++) begin
        vec_act.push_back(DATA_W'($urandom));
        vec_wgt.push_back(DATA_W'($urandom));
      end
      case ($urandom_range(0, 2))
        0: send_vec(DATA_W'($urandom), 32'h7FFF_0000 + 32'($urandom_range(0, 65535)), 1'b1);
        1: send_vec(DATA_W'($urandom), 32'h8000_0000 + 32'($urandom_range(0, 65535)), 1'b1);
        default: send_vec(DATA_W'($urandom), 32'($urandom), 1'b1);
      endcase
    end
    rand_rdy = 1'b0;
    drain();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
